// File: rtl/act_pwl_pkg.sv
// Purpose : shared types and fixed-point constants for the piecewise-linear
//           activation pipeline (tanh / sigmoid).
// Contents: region_e  - segment selector R0..R3
//           *_DEF     - default WIDTH / FRAC / TAG_W
//           B0, B1, B2, OFF_R1, OFF_R2, ONE, HALF - constants at FRAC_DEF
//           fx_scale  - rescales a FRAC_DEF constant to another FRAC
package act_pwl_pkg;

    localparam int unsigned WIDTH_DEF = 24;
    localparam int unsigned FRAC_DEF  = 20;
    localparam int unsigned TAG_W_DEF = 4;

    typedef enum logic [1:0] {
        R0 = 2'd0,
        R1 = 2'd1,
        R2 = 2'd2,
        R3 = 2'd3
    } region_e;

    // Constants held at FRAC_DEF precision; all derive from 1 << FRAC_DEF.
    localparam logic [63:0] HALF   = 64'd1 << (FRAC_DEF - 1);
    localparam logic [63:0] ONE    = HALF << 1;
    localparam logic [63:0] B0     = ONE >> 2;
    localparam logic [63:0] B1     = ONE;
    localparam logic [63:0] B2     = ONE << 2;
    localparam logic [63:0] OFF_R1 = ONE >> 4;
    localparam logic [63:0] OFF_R2 = B0 + HALF;

    // Move a FRAC_DEF constant to a different fractional precision.
    function automatic logic [63:0] fx_scale(logic [63:0] c, int unsigned frac);
        if (frac >= FRAC_DEF) begin
            return c << (frac - FRAC_DEF);
        end
        return c >> (FRAC_DEF - frac);
    endfunction

endpackage

// File: rtl/act_pwl_seg.sv
// Purpose : combinational shift-add evaluator of f(a) for one PWL segment.
// Ports   : a_i      - non-negative magnitude, WIDTH bits
//           region_i - segment (act_pwl_pkg::region_e encoding)
//           f_c_o    - f(a), never above 1.0 (combinational)
module act_pwl_seg
    import act_pwl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned FRAC  = FRAC_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [1:0]       region_i,
    output logic [WIDTH-1:0] f_c_o
);

    localparam logic [WIDTH-1:0] OFF1_W = WIDTH'(fx_scale(OFF_R1, FRAC));
    localparam logic [WIDTH-1:0] OFF2_W = WIDTH'(fx_scale(OFF_R2, FRAC));
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(fx_scale(ONE, FRAC));

    region_e region_c;
    assign region_c = region_e'(region_i);

    // Slope 1, 0.75, 0.0625 or 0 with matching offsets; shifts truncate.
    always_comb begin
        f_c_o = '0;
        case (region_c)
            R0:      f_c_o = a_i;
            R1:      f_c_o = (a_i >> 1) + (a_i >> 2) + OFF1_W;
            R2:      f_c_o = (a_i >> 4) + OFF2_W;
            R3:      f_c_o = ONE_W;
            default: f_c_o = '0;
        endcase
    end

endmodule

// File: rtl/act_pwl_pipe.sv
// Purpose : three-stage pipelined PWL activation (tanh or sigmoid per sample)
//           with valid/ready handshake, bubble collapsing and a sideband tag.
// Ports   : clk, rst_n      - clock, async active-low reset
//           in_valid_i     - input sample valid
//           in_ready_o     - sample accepted this cycle (combinational)
//           in_data_i      - x, two's complement Q(WIDTH-FRAC).FRAC
//           in_mode_i      - 0 = tanh, 1 = sigmoid
//           in_tag_i       - tag returned with the result
//           out_valid_o    - result valid
//           out_ready_i    - downstream accepts result
//           out_data_o     - activation result, same Q format
//           out_tag_o      - tag of the result in out_data_o
module act_pwl_pipe
    import act_pwl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam logic [WIDTH-1:0] B0_W     = WIDTH'(fx_scale(B0, FRAC));
    localparam logic [WIDTH-1:0] B1_W     = WIDTH'(fx_scale(B1, FRAC));
    localparam logic [WIDTH-1:0] B2_W     = WIDTH'(fx_scale(B2, FRAC));
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(fx_scale(ONE, FRAC));
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage valids
    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;

    // S1 payload
    logic             s1_sign_q, s1_sign_d;
    logic [WIDTH-1:0] s1_mag_q, s1_mag_d;
    region_e          s1_region_q, s1_region_d;
    logic             s1_mode_q;
    logic [TAG_W-1:0] s1_tag_q;

    // S2 payload
    logic             s2_sign_q;
    logic [WIDTH-1:0] s2_f_q, s2_f_d;
    logic             s2_mode_q;
    logic [TAG_W-1:0] s2_tag_q;

    // S3 (output) payload
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q;

    // Stage load enables: a stage loads when empty or when it drains this cycle.
    logic en1_c, en2_c, en3_c;
    assign en3_c = ~v3_q | out_ready_i;
    assign en2_c = ~v2_q | en3_c;
    assign en1_c = ~v1_q | en2_c;

    assign in_ready_o = en1_c;
    assign v1_d       = en1_c ? in_valid_i : v1_q;
    assign v2_d       = en2_c ? v1_q : v2_q;
    assign v3_d       = en3_c ? v2_q : v3_q;

    // S1: optional x/2 for sigmoid, sign/magnitude split, region select.
    logic [WIDTH-1:0] u_c;
    always_comb begin
        u_c         = in_mode_i ? {in_data_i[WIDTH-1], in_data_i[WIDTH-1:1]} : in_data_i;
        s1_sign_d   = u_c[WIDTH-1];
        s1_mag_d    = u_c;
        s1_region_d = R0;
        if (u_c == MOST_NEG) begin
            s1_mag_d = MAX_POS;
        end else if (s1_sign_d) begin
            s1_mag_d = -u_c;
        end
        if (s1_mag_d >= B2_W) begin
            s1_region_d = R3;
        end else if (s1_mag_d >= B1_W) begin
            s1_region_d = R2;
        end else if (s1_mag_d >= B0_W) begin
            s1_region_d = R1;
        end
    end

    // S2: segment evaluation
    act_pwl_seg #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_seg (
        .a_i      (s1_mag_q),
        .region_i (s1_region_q),
        .f_c_o    (s2_f_d)
    );

    // S3: sign restore; sigmoid maps t to (t + 1) / 2 with one guard bit.
    logic [WIDTH-1:0] t_c;
    logic [WIDTH:0]   sig_sum_c;
    always_comb begin
        t_c        = s2_sign_q ? -s2_f_q : s2_f_q;
        sig_sum_c  = {t_c[WIDTH-1], t_c} + {1'b0, ONE_W};
        out_data_d = s2_mode_q ? sig_sum_c[WIDTH:1] : t_c;
    end

    // Valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

    // S1 payload register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s1_region_q <= R0;
            s1_mode_q   <= 1'b0;
            s1_tag_q    <= '0;
        end else if (en1_c && in_valid_i) begin
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s1_region_q <= s1_region_d;
            s1_mode_q   <= in_mode_i;
            s1_tag_q    <= in_tag_i;
        end
    end

    // S2 payload register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sign_q <= 1'b0;
            s2_f_q    <= '0;
            s2_mode_q <= 1'b0;
            s2_tag_q  <= '0;
        end else if (en2_c && v1_q) begin
            s2_sign_q <= s1_sign_q;
            s2_f_q    <= s2_f_d;
            s2_mode_q <= s1_mode_q;
            s2_tag_q  <= s1_tag_q;
        end
    end

    // Output register: holds while stalled since en3_c is low then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else if (en3_c && v2_q) begin
            out_data_q <= out_data_d;
            out_tag_q  <= s2_tag_q;
        end
    end

    assign out_valid_o = v3_q;
    assign out_data_o  = out_data_q;
    assign out_tag_o   = out_tag_q;

endmodule

// File: tb/tb_act_pwl_pipe.sv
// Directed bench for act_pwl_pipe: tanh/sigmoid values, saturation and region
// edges, back-to-back stream with stall, bubbles, and mid-stream reset.
module tb_act_pwl_pipe;

    localparam int unsigned W  = 24;
    localparam int unsigned TW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;

    int checks;
    int failures;

    // Hand-computed vectors (Q4.20): tanh table and sigmoid table
    logic [W-1:0] tx [5] = '{24'h080000, 24'hF00000, 24'h500000, 24'h800000, 24'hFE0000};
    logic [W-1:0] te [5] = '{24'h070000, 24'hF30000, 24'h100000, 24'hF00000, 24'hFE0000};
    logic [W-1:0] sx [5] = '{24'h000000, 24'h200000, 24'hE00000, 24'h100000, 24'hA00000};
    logic [W-1:0] se [5] = '{24'h080000, 24'h0E8000, 24'h018000, 24'h0B8000, 24'h008000};

    act_pwl_pipe #(
        .WIDTH (W),
        .FRAC  (20),
        .TAG_W (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_mode_i   (in_mode),
        .in_tag_i    (in_tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_tag_o   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Send one sample into an empty pipe and wait (bounded) for its result.
    task automatic run_one(input logic [W-1:0] x, input logic mode, input logic [TW-1:0] tag,
                           output logic [W-1:0] d, output logic [TW-1:0] tg, output int lat);
        lat       = -1;
        d         = '0;
        tg        = '0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = x;
        in_mode   = mode;
        in_tag    = tag;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (out_valid) begin
                d   = out_data;
                tg  = out_tag;
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
            failures++;
            $display("FAIL reset_state valid=%b data=%h tag=%h expected 0/000000/0", out_valid, out_data, out_tag);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_reset in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_tanh_basic();
        logic [W-1:0] xs [3] = '{24'h000000, 24'h080000, 24'hF00000};
        logic [W-1:0] ex [3] = '{24'h000000, 24'h070000, 24'hF30000};
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                in_valid = 1'b1;
                in_data  = xs[c];
                in_mode  = 1'b0;
                in_tag   = TW'(c + 3);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (c >= 2 && c < 5) begin
                if (out_valid !== 1'b1 || out_data !== ex[c-2] || out_tag !== TW'(c + 1)) begin
                    failures++;
                    $display("FAIL tanh_basic[%0d] valid=%b data=%h tag=%h expected 1/%h/%h",
                             c - 2, out_valid, out_data, out_tag, ex[c-2], TW'(c + 1));
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL tanh_latency cycle=%0d out_valid=%b expected 0", c + 1, out_valid);
            end
        end
    endtask

    task automatic test_tanh_sat();
        logic [W-1:0] xs [4] = '{24'h500000, 24'h800000, 24'h040000, 24'h400000};
        logic [W-1:0] ex [4] = '{24'h100000, 24'hF00000, 24'h040000, 24'h100000};
        logic [W-1:0] d;
        logic [TW-1:0] tg;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_one(xs[i], 1'b0, TW'(i), d, tg, lat);
            checks++;
            if (lat != 3 || d !== ex[i] || tg !== TW'(i)) begin
                failures++;
                $display("FAIL tanh_sat[%0d] data=%h tag=%h lat=%0d expected %h/%h/3", i, d, tg, lat, ex[i], TW'(i));
            end
        end
    endtask

    task automatic test_sigmoid();
        logic [W-1:0] d;
        logic [TW-1:0] tg;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_one(sx[i], 1'b1, TW'(15 - i), d, tg, lat);
            checks++;
            if (lat != 3 || d !== se[i] || tg !== TW'(15 - i)) begin
                failures++;
                $display("FAIL sigmoid[%0d] data=%h tag=%h lat=%0d expected %h/%h/3", i, d, tg, lat, se[i], TW'(15 - i));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d [20];
        int sent;
        int rcv;
        sent = 0;
        rcv  = 0;
        for (int i = 0; i < 20; i++) begin
            exp_d[i] = (i % 2 == 1) ? se[(i / 2) % 5] : te[(i / 2) % 5];
        end
        for (int cyc = 0; cyc < 200 && rcv < 20; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 11);
            if (sent < 20) begin
                in_valid = 1'b1;
                in_mode  = (sent % 2 == 1);
                in_data  = in_mode ? sx[(sent / 2) % 5] : tx[(sent / 2) % 5];
                in_tag   = TW'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== exp_d[rcv] || out_tag !== TW'(rcv)) begin
                    failures++;
                    $display("FAIL stream[%0d] data=%h tag=%h expected %h/%h", rcv, out_data, out_tag, exp_d[rcv], TW'(rcv));
                end
                rcv++;
            end else if (cyc >= 6 && cyc < 11) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_d[rcv] || out_tag !== TW'(rcv)) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d valid=%b data=%h tag=%h expected 1/%h/%h",
                             cyc, out_valid, out_data, out_tag, exp_d[rcv], TW'(rcv));
                end
            end
            if (cyc == 10) begin
                checks++;
                if (in_ready !== 1'b0 || sent - rcv != 3) begin
                    failures++;
                    $display("FAIL stall_full in_ready=%b in_flight=%0d expected 0/3", in_ready, sent - rcv);
                end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (rcv != 20 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_count received=%0d out_valid=%b expected 20/0", rcv, out_valid);
        end
    endtask

    task automatic test_bubbles();
        logic [W-1:0]  bx [2] = '{24'h080000, 24'h200000};
        logic          bm [2] = '{1'b0, 1'b1};
        logic [W-1:0]  be [2] = '{24'h070000, 24'h0E8000};
        logic [TW-1:0] bt [2] = '{4'hA, 4'h5};
        int            off [2] = '{0, 4};
        int sent;
        int rcv;
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = (cyc % 2 == 1);
            if (sent < 2 && cyc >= off[sent]) begin
                in_valid = 1'b1;
                in_data  = bx[sent];
                in_mode  = bm[sent];
                in_tag   = bt[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (rcv >= 2) begin
                    failures++;
                    $display("FAIL bubble_extra data=%h tag=%h expected no output", out_data, out_tag);
                end else if (out_data !== be[rcv] || out_tag !== bt[rcv]) begin
                    failures++;
                    $display("FAIL bubble[%0d] data=%h tag=%h expected %h/%h", rcv, out_data, out_tag, be[rcv], bt[rcv]);
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (rcv != 2) begin
            failures++;
            $display("FAIL bubble_count received=%0d expected 2", rcv);
        end
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] d;
        logic [TW-1:0] tg;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = tx[i];
            in_mode  = 1'b0;
            in_tag   = TW'(i + 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== te[0]) begin
            failures++;
            $display("FAIL rst_precond valid=%b data=%h expected 1/%h", out_valid, out_data, te[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
            failures++;
            $display("FAIL rst_async valid=%b data=%h tag=%h expected 0/000000/0", out_valid, out_data, out_tag);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_stale cycle=%0d out_valid=%b expected 0", c, out_valid);
            end
            @(posedge clk); #1;
        end
        run_one(sx[1], 1'b1, 4'h9, d, tg, lat);
        checks++;
        if (lat != 3 || d !== se[1] || tg !== 4'h9) begin
            failures++;
            $display("FAIL rst_resume data=%h tag=%h lat=%0d expected %h/9/3", d, tg, lat, se[1]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_tanh_basic();
        test_tanh_sat();
        test_sigmoid();
        test_back_to_back();
        test_bubbles();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
